// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet instruction sequencer: instruction bit map,
// idle word and sequencer states.
package corelet_pkg;

    localparam int unsigned INST_W    = 34;
    localparam int unsigned FIELD_A_W = 11;
    localparam int unsigned NUM_VEC_W = 11;

    localparam int unsigned ACC_B      = 33;
    localparam int unsigned CEN_PMEM_B = 32;
    localparam int unsigned WEN_PMEM_B = 31;
    localparam int unsigned A_PMEM_HI  = 30;
    localparam int unsigned A_PMEM_LO  = 20;
    localparam int unsigned CEN_XMEM_B = 19;
    localparam int unsigned WEN_XMEM_B = 18;
    localparam int unsigned A_XMEM_HI  = 17;
    localparam int unsigned A_XMEM_LO  = 7;
    localparam int unsigned OFIFO_RD_B = 6;
    localparam int unsigned IFIFO_WR_B = 5;
    localparam int unsigned IFIFO_RD_B = 4;
    localparam int unsigned L0_RD_B    = 3;
    localparam int unsigned L0_WR_B    = 2;
    localparam int unsigned EXECUTE_B  = 1;
    localparam int unsigned LOAD_B     = 0;

    // Both memories deselected, addresses zero, no strobes.
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        IDLE,
        W_FETCH,
        W_LOAD,
        W_SETTLE,
        A_FETCH,
        EXEC,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/corelet_ctrl_if.sv
// Host/corelet side signals of the sequencer; master is the sequencer itself.
interface corelet_ctrl_if #(
    parameter int unsigned addr_w = 11
);
    import corelet_pkg::*;

    logic                  start;
    logic [NUM_VEC_W-1:0]  num_vec;
    logic [addr_w-1:0]     xmem_base;
    logic [addr_w-1:0]     pmem_base;
    logic                  acc_en;
    logic                  ofifo_valid;
    logic [INST_W-1:0]     inst;
    logic                  busy;
    logic                  done;

    modport master (
        input  start, num_vec, xmem_base, pmem_base, acc_en, ofifo_valid,
        output inst, busy, done
    );

    modport slave (
        output start, num_vec, xmem_base, pmem_base, acc_en, ofifo_valid,
        input  inst, busy, done
    );

endinterface

// File: rtl/psum_drain.sv
// OFIFO-to-pmem drain engine: paced ofifo reads, each followed one word later
// by a pmem write to the next sequential address.
module psum_drain
    import corelet_pkg::*;
#(
    parameter int unsigned addr_w = 11
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 ofifo_valid,
    input  logic [NUM_VEC_W-1:0] num_vec,
    input  logic [addr_w-1:0]    pmem_base,
    output logic                 ofifo_rd_c,
    output logic                 pmem_wr_c,
    output logic [addr_w-1:0]    pmem_addr_c,
    output logic                 all_written_c
);

    logic                 rd_q;
    logic [NUM_VEC_W-1:0] issued_q;
    logic [NUM_VEC_W-1:0] written_q;

    // Skipping the word after a read keeps a stale valid from being read twice.
    assign ofifo_rd_c    = en && ofifo_valid && !rd_q && (issued_q < num_vec);
    assign pmem_wr_c     = rd_q;
    assign pmem_addr_c   = pmem_base + addr_w'(written_q);
    assign all_written_c = (written_q == num_vec);

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            rd_q      <= 1'b0;
            issued_q  <= '0;
            written_q <= '0;
        end else begin
            rd_q <= ofifo_rd_c;
            if (ofifo_rd_c) issued_q  <= issued_q + NUM_VEC_W'(1);
            if (pmem_wr_c)  written_q <= written_q + NUM_VEC_W'(1);
        end
    end

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet instruction sequencer: weight fetch/load/settle, activation stream,
// and psum drain, emitted as a registered 34-bit instruction word.
module corelet_ctrl
    import corelet_pkg::*;
#(
    parameter int unsigned row    = 8,
    parameter int unsigned col    = 8,
    parameter int unsigned addr_w = 11
) (
    input  logic           clk,
    input  logic           reset,
    corelet_ctrl_if.master bus
);

    localparam int unsigned CNT_W = NUM_VEC_W + 1;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     limit_c;
    logic                 cnt_last_c;

    logic [NUM_VEC_W-1:0] num_vec_q;
    logic [addr_w-1:0]    xmem_base_q;
    logic [addr_w-1:0]    pmem_base_q;
    logic                 acc_q;

    logic [INST_W-1:0]    inst_d, inst_q;
    logic                 xrd_q;
    logic                 busy_q, done_q;

    logic                 drain_en_c, drain_clr_c;
    logic                 ofifo_rd_c, pmem_wr_c, all_written_c;
    logic [addr_w-1:0]    pmem_addr_c;

    assign drain_en_c  = (state_q == EXEC) || (state_q == DRAIN);
    assign drain_clr_c = (state_q == IDLE);

    psum_drain #(.addr_w(addr_w)) u_drain (
        .clk          (clk),
        .reset        (reset),
        .en           (drain_en_c),
        .clr          (drain_clr_c),
        .ofifo_valid  (bus.ofifo_valid),
        .num_vec      (num_vec_q),
        .pmem_base    (pmem_base_q),
        .ofifo_rd_c   (ofifo_rd_c),
        .pmem_wr_c    (pmem_wr_c),
        .pmem_addr_c  (pmem_addr_c),
        .all_written_c(all_written_c)
    );

    // Length of each counted phase.
    always_comb begin
        limit_c = '0;
        case (state_q)
            W_FETCH, W_LOAD: limit_c = CNT_W'(col);
            W_SETTLE:        limit_c = CNT_W'(row + col);
            A_FETCH, EXEC:   limit_c = CNT_W'(num_vec_q);
            default:         limit_c = '0;
        endcase
    end

    assign cnt_last_c = (cnt_q == limit_c - CNT_W'(1));

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.start)    state_d = W_FETCH;
            W_FETCH:  if (cnt_last_c)   state_d = W_LOAD;
            W_LOAD:   if (cnt_last_c)   state_d = W_SETTLE;
            W_SETTLE: if (cnt_last_c)   state_d = (num_vec_q == '0) ? DONE : A_FETCH;
            A_FETCH:  if (cnt_last_c)   state_d = EXEC;
            EXEC:     if (cnt_last_c)   state_d = DRAIN;
            DRAIN:    if (all_written_c) state_d = DONE;
            DONE:                        state_d = IDLE;
            default:                     state_d = IDLE;
        endcase
    end

    // Phase counter restarts on every state change.
    always_ff @(posedge clk) begin
        if (!reset)                                     cnt_q <= '0;
        else if (state_d != state_q || state_q == IDLE) cnt_q <= '0;
        else                                            cnt_q <= cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            num_vec_q   <= '0;
            xmem_base_q <= '0;
            pmem_base_q <= '0;
            acc_q       <= 1'b0;
        end else if (state_q == IDLE && bus.start) begin
            num_vec_q   <= bus.num_vec;
            xmem_base_q <= bus.xmem_base;
            pmem_base_q <= bus.pmem_base;
            acc_q       <= bus.acc_en;
        end
    end

    // Next instruction word; drain fields are disjoint from the phase fields.
    always_comb begin
        inst_d             = INST_IDLE;
        inst_d[L0_WR_B]    = xrd_q;
        inst_d[IFIFO_WR_B] = 1'b0;
        inst_d[IFIFO_RD_B] = 1'b0;
        case (state_q)
            W_FETCH: begin
                inst_d[CEN_XMEM_B]          = 1'b0;
                inst_d[A_XMEM_HI:A_XMEM_LO] = FIELD_A_W'(xmem_base_q + addr_w'(cnt_q));
            end
            W_LOAD: begin
                inst_d[L0_RD_B] = 1'b1;
                inst_d[LOAD_B]  = 1'b1;
            end
            A_FETCH: begin
                inst_d[CEN_XMEM_B]          = 1'b0;
                inst_d[A_XMEM_HI:A_XMEM_LO] =
                    FIELD_A_W'(xmem_base_q + addr_w'(col) + addr_w'(cnt_q));
            end
            EXEC: begin
                inst_d[L0_RD_B]   = 1'b1;
                inst_d[EXECUTE_B] = 1'b1;
            end
            default: ;
        endcase
        inst_d[OFIFO_RD_B] = ofifo_rd_c;
        if (pmem_wr_c) begin
            inst_d[CEN_PMEM_B]          = 1'b0;
            inst_d[WEN_PMEM_B]          = 1'b0;
            inst_d[A_PMEM_HI:A_PMEM_LO] = FIELD_A_W'(pmem_addr_c);
            inst_d[ACC_B]               = acc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            inst_q <= INST_IDLE;
            xrd_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            inst_q <= inst_d;
            xrd_q  <= !inst_d[CEN_XMEM_B];
            busy_q <= (state_d != IDLE) && (state_d != DONE);
            done_q <= (state_d == DONE);
        end
    end

    assign bus.inst = inst_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: decodes every instruction word of a pass and
// compares phase counts, addresses and ordering against hand-computed values.
module tb_corelet_ctrl;
    import corelet_pkg::*;

    localparam int unsigned ROW = 8;
    localparam int unsigned COL = 8;
    localparam int unsigned AW  = 11;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    corelet_ctrl_if #(.addr_w(AW)) bus ();

    corelet_ctrl #(.row(ROW), .col(COL), .addr_w(AW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Runs one pass and checks it; glitch pulses start mid-pass and on done.
    task automatic run_pass(input string name, input int nv, input int xb, input int pb,
                            input bit acc, input bit rnd_valid, input bit glitch);
        int n_xrd, n_l0wr, n_load, n_exec, n_ofrd, n_pwr, n_settle, n_done, pwr_at_done;
        int addr_err, lag_err, b2b_err, wrlag_err, acc_err, ififo_err, busy_post;
        int idle_run, cyc, post;
        logic prev_xrd, prev_rd, after_load, xrd, pwr, busy_start;
        logic [INST_W-1:0] w;
        logic [10:0] a_x, a_p;
        n_xrd = 0; n_l0wr = 0; n_load = 0; n_exec = 0; n_ofrd = 0; n_pwr = 0;
        n_settle = -1; n_done = 0; pwr_at_done = -1;
        addr_err = 0; lag_err = 0; b2b_err = 0; wrlag_err = 0; acc_err = 0;
        ififo_err = 0; busy_post = 0; idle_run = 0; cyc = 0; post = -1;
        prev_xrd = 1'b0; prev_rd = 1'b0; after_load = 1'b0;

        @(negedge clk);
        bus.num_vec   = 11'(nv);
        bus.xmem_base = AW'(xb);
        bus.pmem_base = AW'(pb);
        bus.acc_en    = acc;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        busy_start = bus.busy;
        // Scramble the inputs: the pass must run from the latched copies.
        bus.num_vec   = 11'(nv + 5);
        bus.xmem_base = AW'(xb + 3);
        bus.pmem_base = AW'(pb + 7);
        bus.acc_en    = ~acc;

        while (post < 3 && cyc < 3000) begin
            w   = bus.inst;
            xrd = !w[CEN_XMEM_B] && w[WEN_XMEM_B];
            if (!w[CEN_XMEM_B] && !w[WEN_XMEM_B]) addr_err++;
            if (w[L0_WR_B] !== prev_xrd) lag_err++;
            if (w[L0_WR_B]) n_l0wr++;
            if (xrd) begin
                a_x = 11'(xb + n_xrd);
                if (w[A_XMEM_HI:A_XMEM_LO] !== a_x) addr_err++;
                n_xrd++;
            end
            if (w[LOAD_B])    n_load++;
            if (w[EXECUTE_B]) n_exec++;
            if (w[IFIFO_WR_B] || w[IFIFO_RD_B]) ififo_err++;
            if (w[OFIFO_RD_B]) begin
                n_ofrd++;
                if (prev_rd) b2b_err++;
            end
            pwr = !w[CEN_PMEM_B] && !w[WEN_PMEM_B];
            if (pwr !== prev_rd) wrlag_err++;
            if (pwr) begin
                a_p = 11'(pb + n_pwr);
                if (w[A_PMEM_HI:A_PMEM_LO] !== a_p) addr_err++;
                if (w[ACC_B] !== acc) acc_err++;
                n_pwr++;
            end else if (w[ACC_B]) acc_err++;
            if (w[LOAD_B]) begin
                after_load = 1'b1;
                idle_run   = 0;
            end else if (after_load) begin
                if (w === INST_IDLE) idle_run++;
                else begin
                    n_settle   = idle_run;
                    after_load = 1'b0;
                end
            end
            prev_xrd = xrd;
            prev_rd  = w[OFIFO_RD_B];

            bus.start = 1'b0;
            if (glitch && cyc == 20) bus.start = 1'b1;
            if (bus.done) begin
                n_done++;
                if (post < 0) begin
                    post        = 0;
                    pwr_at_done = n_pwr;
                    if (after_load) n_settle = idle_run;
                    if (glitch) bus.start = 1'b1;
                end
            end
            if (post >= 0) begin
                if (bus.busy) busy_post++;
                post++;
            end
            if (rnd_valid) bus.ofifo_valid = 1'($urandom_range(0, 1));
            cyc++;
            @(negedge clk);
        end
        bus.start = 1'b0;

        check({name, ".finished"},    64'(post >= 0), 64'd1);
        check({name, ".busy_start"},  busy_start, 1);
        check({name, ".xmem_reads"},  n_xrd, COL + nv);
        check({name, ".l0_wr"},       n_l0wr, COL + nv);
        check({name, ".load"},        n_load, COL);
        check({name, ".settle"},      n_settle, ROW + COL);
        check({name, ".execute"},     n_exec, nv);
        check({name, ".ofifo_rd"},    n_ofrd, nv);
        check({name, ".pmem_wr"},     n_pwr, nv);
        check({name, ".wr_at_done"},  pwr_at_done, nv);
        check({name, ".done_pulses"}, n_done, 1);
        check({name, ".addr_err"},    addr_err, 0);
        check({name, ".l0wr_lag"},    lag_err, 0);
        check({name, ".ofifo_b2b"},   b2b_err, 0);
        check({name, ".pmem_lag"},    wrlag_err, 0);
        check({name, ".acc_bit"},     acc_err, 0);
        check({name, ".ififo"},       ififo_err, 0);
        check({name, ".busy_after"},  busy_post, 0);
        check({name, ".end_idle"},    bus.inst, INST_IDLE);
    endtask

    initial begin
        bit seen_exec;
        bus.start       = 1'b0;
        bus.num_vec     = '0;
        bus.xmem_base   = '0;
        bus.pmem_base   = '0;
        bus.acc_en      = 1'b0;
        bus.ofifo_valid = 1'b1;
        reset           = 1'b0;
        repeat (3) @(negedge clk);
        check("reset.inst", bus.inst, INST_IDLE);
        check("reset.busy", bus.busy, 0);
        check("reset.done", bus.done, 0);
        reset = 1'b1;

        run_pass("basic", 4, 'h010, 'h100, 1'b0, 1'b0, 1'b0);
        run_pass("nv0",   0, 'h020, 'h000, 1'b0, 1'b0, 1'b0);
        run_pass("rndv", 10, 'h040, 'h200, 1'b0, 1'b1, 1'b0);
        bus.ofifo_valid = 1'b1;
        run_pass("wrap",  3, 'h000, 'h7FE, 1'b1, 1'b0, 1'b0);
        run_pass("glitch", 5, 'h100, 'h300, 1'b0, 1'b0, 1'b1);

        // Reset asserted for one edge in the middle of execute.
        @(negedge clk);
        bus.num_vec   = 11'd16;
        bus.xmem_base = 11'h050;
        bus.pmem_base = 11'h400;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        seen_exec = 1'b0;
        for (int i = 0; i < 200 && !seen_exec; i++) begin
            if (bus.inst[EXECUTE_B]) seen_exec = 1'b1;
            else @(negedge clk);
        end
        check("rst.reached_exec", 64'(seen_exec), 64'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst.inst", bus.inst, INST_IDLE);
        check("rst.busy", bus.busy, 0);
        check("rst.done", bus.done, 0);
        reset = 1'b1;
        run_pass("post_rst", 4, 'h010, 'h100, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
